// File: rtl/sram_agg_serializer.sv
// sram_agg_serializer
//   Access controller for a single-port SRAM bank of 2^ADDR_WIDTH lines, each
//   line FETCH_WIDTH lanes of DATA_WIDTH bits, with a 1-cycle read latency.
//   Write side packs a DATA_WIDTH stream into full lines and writes them at an
//   auto-incrementing line address. Read side accepts line-address requests,
//   reads the bank and serialises the lanes back out, lane 0 first.
//   Only one bank access happens per cycle, and a pending line write wins.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   clk_en               global enable; all state holds while low
//   flush                synchronous soft clear (overrides clk_en)
//   data_in*             write stream (valid/ready)
//   wr_addr              line address the next line write will use
//   rd_req_*             read request stream (valid/ready)
//   data_out*            read data stream (valid/ready)
//   mem_*_bank           bank interface: cen/wen active high, Q valid the
//                        cycle after a read access and held while unaccessed
module sram_agg_serializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic                                  flush,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  input  logic                                  data_in_valid,
  output logic                                  data_in_ready,
  output logic [ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [ADDR_WIDTH-1:0]                 rd_req_addr,
  input  logic                                  rd_req_valid,
  output logic                                  rd_req_ready,
  output logic [DATA_WIDTH-1:0]                 data_out,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ready,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_in_bank,
  output logic                                  mem_cen_in_bank,
  output logic                                  mem_wen_in_bank,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] mem_data_in_bank,
  input  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] mem_data_out_bank
);

  localparam int IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FETCH_WIDTH - 1);

  typedef logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] line_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_SER} rd_state_e;

  line_t                 agg_q, agg_d;
  logic [IDX_W-1:0]      agg_cnt_q, agg_cnt_d;
  logic                  agg_full_q, agg_full_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  rd_state_e             rd_state_q, rd_state_d;
  line_t                 ser_q, ser_d;
  logic [IDX_W-1:0]      ser_idx_q, ser_idx_d;

  logic wr_hs, rd_hs, out_hs, wr_issue;

  // Handshakes and bank port. A full aggregation buffer owns the bank for one
  // cycle and blocks both input streams, which keeps a line write ahead of any
  // read accepted after its last word.
  always_comb begin
    data_in_ready    = clk_en & ~flush & ~agg_full_q;
    rd_req_ready     = clk_en & ~flush & ~agg_full_q & (rd_state_q == RD_IDLE);
    data_out_valid   = clk_en & (rd_state_q == RD_SER);
    data_out         = ser_q[ser_idx_q];
    wr_hs            = data_in_valid & data_in_ready;
    rd_hs            = rd_req_valid & rd_req_ready;
    out_hs           = data_out_valid & data_out_ready;
    wr_issue         = clk_en & ~flush & agg_full_q;
    mem_cen_in_bank  = wr_issue | rd_hs;
    mem_wen_in_bank  = wr_issue;
    // wr_issue and rd_hs are mutually exclusive, so the read address only
    // needs to win when a request is actually being accepted.
    mem_addr_in_bank = rd_hs ? rd_req_addr : wr_ptr_q;
    mem_data_in_bank = agg_q;
    wr_addr          = wr_ptr_q;
  end

  // NOTE: every next-state signal takes its hold value first so that no path
  // through the branches below leaves it unassigned and infers a latch.
  always_comb begin
    agg_d      = agg_q;
    agg_cnt_d  = agg_cnt_q;
    agg_full_d = agg_full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_state_d = rd_state_q;
    ser_d      = ser_q;
    ser_idx_d  = ser_idx_q;

    if (flush) begin
      // Drops a partial line, a pending line write and any read in flight.
      agg_d      = '0;
      agg_cnt_d  = '0;
      agg_full_d = 1'b0;
      wr_ptr_d   = '0;
      rd_state_d = RD_IDLE;
      ser_d      = '0;
      ser_idx_d  = '0;
    end else if (clk_en) begin
      if (wr_hs) begin
        agg_d[agg_cnt_q] = data_in;
        if (agg_cnt_q == LAST_IDX) begin
          agg_cnt_d  = '0;
          agg_full_d = 1'b1;
        end else begin
          agg_cnt_d = agg_cnt_q + IDX_W'(1);
        end
      end
      if (agg_full_q) begin
        // The write is on the bank this cycle; pointer wraps silently.
        agg_full_d = 1'b0;
        wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
      end

      case (rd_state_q)
        RD_IDLE: if (rd_hs) rd_state_d = RD_WAIT;
        RD_WAIT: begin
          // Bank Q is held while unaccessed, so capturing after a clk_en
          // stall still sees the requested line.
          ser_d      = mem_data_out_bank;
          ser_idx_d  = '0;
          rd_state_d = RD_SER;
        end
        RD_SER: begin
          if (out_hs) begin
            if (ser_idx_q == LAST_IDX) begin
              ser_idx_d  = '0;
              rd_state_d = RD_IDLE;
            end else begin
              ser_idx_d = ser_idx_q + IDX_W'(1);
            end
          end
        end
        default: rd_state_d = RD_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      agg_q      <= '0;
      agg_cnt_q  <= '0;
      agg_full_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_state_q <= RD_IDLE;
      ser_q      <= '0;
      ser_idx_q  <= '0;
    end else begin
      agg_q      <= agg_d;
      agg_cnt_q  <= agg_cnt_d;
      agg_full_q <= agg_full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_state_q <= rd_state_d;
      ser_q      <= ser_d;
      ser_idx_q  <= ser_idx_d;
    end
  end

endmodule

// File: tb/tb_sram_agg_serializer.sv
// Bench for sram_agg_serializer: a bank model on the SRAM side, a line-level
// reference model with a per-cycle compare process, and directed scenarios
// carrying hand-computed expectations.
module tb_sram_agg_serializer;

  localparam int DW = 16;
  localparam int FW = 4;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst, clk_en, flush;
  logic [DW-1:0]     data_in;
  logic              data_in_valid, data_in_ready;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_req_addr;
  logic              rd_req_valid, rd_req_ready;
  logic [DW-1:0]     data_out;
  logic              data_out_valid, data_out_ready;
  logic [AW-1:0]     mem_addr_in_bank;
  logic              mem_cen_in_bank, mem_wen_in_bank;
  logic [FW-1:0][DW-1:0] mem_data_in_bank;
  logic [FW-1:0][DW-1:0] mem_data_out_bank = '0;

  always #5 clk = ~clk;

  sram_agg_serializer #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .clk_en            (clk_en),
    .flush             (flush),
    .data_in           (data_in),
    .data_in_valid     (data_in_valid),
    .data_in_ready     (data_in_ready),
    .wr_addr           (wr_addr),
    .rd_req_addr       (rd_req_addr),
    .rd_req_valid      (rd_req_valid),
    .rd_req_ready      (rd_req_ready),
    .data_out          (data_out),
    .data_out_valid    (data_out_valid),
    .data_out_ready    (data_out_ready),
    .mem_addr_in_bank  (mem_addr_in_bank),
    .mem_cen_in_bank   (mem_cen_in_bank),
    .mem_wen_in_bank   (mem_wen_in_bank),
    .mem_data_in_bank  (mem_data_in_bank),
    .mem_data_out_bank (mem_data_out_bank)
  );

  // Bank: 1-cycle read latency, Q held while not read.
  logic [63:0] bank [256] = '{default: '0};
  always @(posedge clk) begin
    if (mem_cen_in_bank) begin
      if (mem_wen_in_bank) bank[mem_addr_in_bank] <= mem_data_in_bank;
      else                 mem_data_out_bank <= bank[mem_addr_in_bank];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Lines are numbered in arrival order since the last clear; line n lands at
  // address n mod 256 one cycle after its last word. A read returns what the
  // bank held when it was accepted, lane 0 first, starting 2 active cycles on.
  logic [63:0] model_mem [256] = '{default: '0};
  logic [7:0]  pend_addr_q [$];
  logic [63:0] pend_data_q [$];
  logic [15:0] out_q [$];
  logic [63:0] cur_line = '0;
  logic [63:0] rline;
  int          cur_n = 0, lines_acc = 0, lines_iss = 0, lat = 0;
  bit          exp_wr, exp_rd_rdy, rd_acc, exp_valid;

  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        check("flush_no_access", mem_cen_in_bank, 0);
        check("flush_wr_addr", wr_addr, lines_iss[7:0]);
        pend_addr_q.delete(); pend_data_q.delete(); out_q.delete();
        cur_n = 0; lines_acc = 0; lines_iss = 0; lat = 0;
      end else if (!clk_en) begin
        check("gated_outputs", {data_in_ready, rd_req_ready, data_out_valid, mem_cen_in_bank}, 0);
      end else begin
        exp_wr     = pend_addr_q.size() != 0;
        exp_rd_rdy = !exp_wr && out_q.size() == 0;
        rd_acc     = rd_req_valid && exp_rd_rdy;
        check("data_in_ready", data_in_ready, !exp_wr);
        check("rd_req_ready", rd_req_ready, exp_rd_rdy);
        check("wr_addr", wr_addr, lines_iss[7:0]);
        check("mem_cen", mem_cen_in_bank, exp_wr || rd_acc);
        if (exp_wr) begin
          check("mem_wen_wr", mem_wen_in_bank, 1);
          check("mem_addr_wr", mem_addr_in_bank, pend_addr_q[0]);
          check("mem_data_wr", mem_data_in_bank, pend_data_q[0]);
          void'(pend_addr_q.pop_front());
          void'(pend_data_q.pop_front());
          lines_iss++;
        end else if (rd_acc) begin
          check("mem_wen_rd", mem_wen_in_bank, 0);
          check("mem_addr_rd", mem_addr_in_bank, rd_req_addr);
        end
        exp_valid = out_q.size() != 0 && lat == 0;
        check("data_out_valid", data_out_valid, exp_valid);
        if (exp_valid && data_out_ready) begin
          check("data_out", data_out, out_q[0]);
          void'(out_q.pop_front());
        end
        if (out_q.size() != 0 && lat > 0) lat--;
        // Reads see the bank before a line completing in the same cycle.
        if (rd_acc) begin
          rline = model_mem[rd_req_addr];
          for (int k = 0; k < FW; k++) out_q.push_back(rline[k*16 +: 16]);
          lat = 1;
        end
        if (data_in_valid && !exp_wr) begin
          cur_line[cur_n*16 +: 16] = data_in;
          cur_n++;
          if (cur_n == FW) begin
            pend_addr_q.push_back(lines_acc[7:0]);
            pend_data_q.push_back(cur_line);
            model_mem[lines_acc[7:0]] = cur_line;
            lines_acc++;
            cur_n = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] got [4];
  int          got_n;

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    int t = 0;
    data_in = w;
    data_in_valid = 1'b1;
    @(negedge clk);
    while (!data_in_ready && t < 50) begin
      next_cycle();
      @(negedge clk);
      t++;
    end
    if (!data_in_ready) check("write_timeout", 0, 1);
    next_cycle();
    data_in_valid = 1'b0;
  endtask

  // Writes line n (words 4n+1..4n+4) and returns the address the bank saw.
  task automatic write_line(input int n, output logic [7:0] a);
    for (int k = 0; k < FW; k++) write_word(16'(n*4 + k + 1));
    @(negedge clk);
    check("wl_write_issued", {mem_cen_in_bank, mem_wen_in_bank}, 2'b11);
    a = mem_addr_in_bank;
    next_cycle();
  endtask

  task automatic request(input logic [7:0] a);
    int t = 0;
    rd_req_addr = a;
    rd_req_valid = 1'b1;
    @(negedge clk);
    while (!rd_req_ready && t < 50) begin
      next_cycle();
      @(negedge clk);
      t++;
    end
    if (!rd_req_ready) check("request_timeout", 0, 1);
    next_cycle();
    rd_req_valid = 1'b0;
  endtask

  task automatic collect(input bit rnd);
    got_n = 0;
    for (int c = 0; c < 300 && got_n < 4; c++) begin
      if (rnd) begin
        clk_en = ($urandom_range(0, 2) != 0);
        data_out_ready = $urandom_range(0, 1);
      end
      @(negedge clk);
      if (clk_en && data_out_valid && data_out_ready) begin
        got[got_n] = data_out;
        got_n++;
      end
      next_cycle();
    end
    clk_en = 1'b1;
    data_out_ready = 1'b1;
    check("collect_count", got_n, 4);
  endtask

  task automatic check_got(input string name, input logic [15:0] base);
    for (int k = 0; k < 4; k++) check(name, got[k], base + 16'(k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] a;

  initial begin
    rst = 1'b1; clk_en = 1'b1; flush = 1'b0;
    data_in = '0; data_in_valid = 1'b0;
    rd_req_addr = '0; rd_req_valid = 1'b0; data_out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_data_out_valid", data_out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_mem_cen", mem_cen_in_bank, 0);
    check("rst_mem_wen", mem_wen_in_bank, 0);
    check("rst_mem_addr", mem_addr_in_bank, 0);
    check("rst_mem_data", mem_data_in_bank, 0);
    check("rst_data_in_ready", data_in_ready, 1);
    check("rst_rd_req_ready", rd_req_ready, 1);
    next_cycle();
    rst = 1'b0;

    // 1: one line write, back-to-back words.
    for (int k = 0; k < 4; k++) begin
      data_in = 16'(k + 1);
      data_in_valid = 1'b1;
      @(negedge clk);
      check("t1_in_ready", data_in_ready, 1);
      next_cycle();
    end
    data_in_valid = 1'b0;
    @(negedge clk);
    check("t1_cen_wen", {mem_cen_in_bank, mem_wen_in_bank}, 2'b11);
    check("t1_addr", mem_addr_in_bank, 8'h00);
    check("t1_lanes", mem_data_in_bank, 64'h0004_0003_0002_0001);
    check("t1_ready_low", data_in_ready, 0);
    next_cycle();
    @(negedge clk);
    check("t1_wr_addr", wr_addr, 8'h01);
    check("t1_ready_back", data_in_ready, 1);
    next_cycle();

    // 2: read line 0 with the sink always ready.
    rd_req_addr = 8'h00;
    rd_req_valid = 1'b1;
    data_out_ready = 1'b1;
    @(negedge clk);
    check("t2_req_ready", rd_req_ready, 1);
    check("t2_cen_wen", {mem_cen_in_bank, mem_wen_in_bank}, 2'b10);
    check("t2_addr", mem_addr_in_bank, 8'h00);
    next_cycle();
    rd_req_valid = 1'b0;
    @(negedge clk);
    check("t2_wait_valid", data_out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      check("t2_valid", data_out_valid, 1);
      check("t2_data", data_out, 16'(k + 1));
    end
    next_cycle();
    @(negedge clk);
    check("t2_req_ready_again", rd_req_ready, 1);
    check("t2_valid_done", data_out_valid, 0);
    next_cycle();

    // 3: random sink and clk_en stalls, including one during RD_WAIT.
    rd_req_addr = 8'h00;
    rd_req_valid = 1'b1;
    @(negedge clk);
    check("t3_req_ready", rd_req_ready, 1);
    next_cycle();
    rd_req_valid = 1'b0;
    clk_en = 1'b0;
    @(negedge clk);
    check("t3_gated", {data_in_ready, rd_req_ready, data_out_valid, mem_cen_in_bank}, 0);
    next_cycle();
    clk_en = 1'b1;
    collect(1'b1);
    check_got("t3_words", 16'h0001);

    // 4: read request in the agg_full cycle waits one cycle, sees new line.
    for (int k = 0; k < 4; k++) write_word(16'h0101 + 16'(k));
    rd_req_addr = 8'h01;
    rd_req_valid = 1'b1;
    @(negedge clk);
    check("t4_req_blocked", rd_req_ready, 0);
    check("t4_write", {mem_cen_in_bank, mem_wen_in_bank}, 2'b11);
    check("t4_write_addr", mem_addr_in_bank, 8'h01);
    next_cycle();
    @(negedge clk);
    check("t4_req_ready", rd_req_ready, 1);
    check("t4_read", {mem_cen_in_bank, mem_wen_in_bank}, 2'b10);
    check("t4_read_addr", mem_addr_in_bank, 8'h01);
    next_cycle();
    rd_req_valid = 1'b0;
    collect(1'b0);
    check_got("t4_words", 16'h0101);

    // 5: 257 lines from a clean pointer; the last one overwrites line 0.
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    for (int n = 0; n < 257; n++) begin
      write_line(n, a);
      if (n == 0)   check("t5_first_addr", a, 8'h00);
      if (n == 255) check("t5_addr_255", a, 8'hFF);
      if (n == 256) check("t5_addr_wrap", a, 8'h00);
    end
    request(8'h00);
    collect(1'b0);
    check_got("t5_words", 16'h0401);

    // 6: flush with a partial line and a read in RD_WAIT.
    write_word(16'hAAA1);
    write_word(16'hAAA2);
    rd_req_addr = 8'h05;
    rd_req_valid = 1'b1;
    @(negedge clk);
    check("t6_req_ready", rd_req_ready, 1);
    next_cycle();
    rd_req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("t6_no_access", mem_cen_in_bank, 0);
    check("t6_readies", {data_in_ready, rd_req_ready}, 2'b00);
    next_cycle();
    flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t6_no_valid", data_out_valid, 0);
      check("t6_wr_addr", wr_addr, 8'h00);
      next_cycle();
    end
    write_line(100, a);
    check("t6_line_addr", a, 8'h00);
    request(8'h00);
    collect(1'b0);
    check_got("t6_words", 16'h0191);

    check("model_drained", out_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
